// File: rtl/matrix_result_collector.sv
// matrix_result_collector
//   Collects a serial stream of 9 result elements (valid/ready handshake) into
//   a 3x3 register array in row-major order, then presents the whole matrix
//   downstream until it is acknowledged.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   en         : acceptance enable; 0 freezes stream intake
//   flush      : synchronous abort back to an empty COLLECT state
//   in_valid   : in_data / in_last valid this cycle
//   in_ready   : element can be accepted this cycle
//   in_data    : result element
//   in_last    : marks the 9th element of a matrix
//   out_valid  : full 3x3 matrix held on out_matrix
//   out_ack    : downstream has consumed out_matrix
//   out_matrix : element k = row*3+col at bits [k*DATA_W +: DATA_W]
//   row, col   : position of the next write (0..2 each)
//   count      : elements accepted into the current matrix (0..9)
//   err        : sticky framing error (early or missing in_last)
module matrix_result_collector #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ack,
  output logic [9*DATA_W-1:0]   out_matrix,
  output logic [1:0]            row,
  output logic [1:0]            col,
  output logic [3:0]            count,
  output logic                  err
);

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  row_reg, row_next;
  logic [1:0]  col_reg, col_next;
  logic [3:0]  count_reg, count_next;
  logic        err_reg, err_next;

  logic        accept;
  logic        last_slot;
  logic [3:0]  wr_idx;

  logic [DATA_W-1:0] elem_reg [9];

  // in_ready deliberately ignores in_valid so upstream can rely on it
  // without a combinational loop through its own valid logic.
  assign in_ready  = (state_reg == COLLECT) & en & ~flush;
  assign accept    = in_valid & in_ready;
  assign last_slot = (row_reg == 2'd2) && (col_reg == 2'd2);
  assign wr_idx    = ({2'b00, row_reg} * 4'd3) + {2'b00, col_reg};

  // ---------------------------------------------------------------------------
  // State / index registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= COLLECT;
      row_reg   <= 2'd0;
      col_reg   <= 2'd0;
      count_reg <= 4'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
      count_reg <= count_next;
      err_reg   <= err_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Flush outranks both accept and ack; accept is already
  // blocked during flush through in_ready, so element registers keep their
  // contents on a flush.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    count_next = count_reg;
    err_next   = err_reg;

    if (flush) begin
      state_next = COLLECT;
      row_next   = 2'd0;
      col_next   = 2'd0;
      count_next = 4'd0;
      err_next   = 1'b0;
    end else if (state_reg == COLLECT) begin
      if (accept) begin
        if (last_slot) begin
          // 9th element: wrap indices, park count at 9 and present the matrix.
          state_next = FULL;
          row_next   = 2'd0;
          col_next   = 2'd0;
          count_next = 4'd9;
          if (!in_last) begin
            err_next = 1'b1;
          end
        end else begin
          if (col_reg == 2'd2) begin
            col_next = 2'd0;
            row_next = row_reg + 2'd1;
          end else begin
            col_next = col_reg + 2'd1;
          end
          count_next = count_reg + 4'd1;
          // Early last: flag it but keep collecting.
          if (in_last && (count_reg != 4'd8)) begin
            err_next = 1'b1;
          end
        end
      end
    end else begin
      // FULL: ack is honoured whatever en says. The ack cycle itself cannot
      // accept because in_ready is low in FULL, giving a 1-cycle bubble.
      if (out_ack) begin
        state_next = COLLECT;
        count_next = 4'd0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Element storage: one register per matrix position. Not cleared on ack;
  // the next matrix simply overwrites it.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 9; gi++) begin : g_elem
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          elem_reg[gi] <= '0;
        end else if (accept && (wr_idx == 4'(gi))) begin
          elem_reg[gi] <= in_data;
        end
      end
      assign out_matrix[gi*DATA_W +: DATA_W] = elem_reg[gi];
    end
  endgenerate

  assign out_valid = (state_reg == FULL);
  assign row       = row_reg;
  assign col       = col_reg;
  assign count     = count_reg;
  assign err       = err_reg;

endmodule
